// File: rtl/chip_top_1127a0.sv
// chip_top_1127a0: I2C-slave register file driving power-stage enables, CC Rp, GPIO pads and TST mux.
// Latency: inputs 2 clk sync (+1 clk majority filter under I2C_GLITCH_FILTER_EN); writes land 1 clk after data bit 8.
// Backpressure: none; no clock stretching, SCL must be at most clk/16.
module chip_top_1127a0 #(
    parameter logic [6:0] I2C_ADDR = 7'h4A,
    parameter logic [7:0] CHIP_ID  = 8'h27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic       tst_i,
    input  logic [4:0] gpio_i,
    output logic [4:0] gpio_o,
    output logic [4:0] gpio_oe,
    input  logic       cc1_cmp_i,
    input  logic       cc2_cmp_i,
    input  logic       dp_cmp_i,
    input  logic       dn_cmp_i,
    input  logic       ts_cmp_i,
    input  logic       ocp_i,
    output logic       gate_en,
    output logic       buck_en,
    output logic       vdrv_en,
    output logic [1:0] cc_rp_en
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WDATA, ACK_W, RDATA, ACK_R
    } i2c_state_t;

    localparam int NS = 14;

    logic [NS-1:0] sync_q1, sync_q2;
    logic          scl_s, sda_s, tst_s, cc1_s, cc2_s, dp_s, dn_s, ts_s, ocp_s;
    logic [4:0]    gpio_s;
    logic          scl_f, sda_f, scl_d, sda_d;
    logic          scl_rise, scl_fall, start_c, stop_c;

    i2c_state_t    state, state_nxt;
    logic [3:0]    bit_cnt;
    logic [6:0]    rx_sr;
    logic [7:0]    rx_byte, tx_sr, ptr, rd_data;
    logic          rw, m_nack, byte_done;
    logic          ptr_ld, wr_en, tx_ld;

    logic [4:0]    ctrl, gpio_out, gpio_oe_r;
    logic [7:0]    scratch;
    logic          ocp_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {scl_i, sda_i, tst_i, gpio_i, cc1_cmp_i, cc2_cmp_i,
                        dp_cmp_i, dn_cmp_i, ts_cmp_i, ocp_i};
            sync_q2 <= sync_q1;
        end
    end

    assign {scl_s, sda_s, tst_s, gpio_s, cc1_s, cc2_s, dp_s, dn_s, ts_s, ocp_s} = sync_q2;

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_h, sda_h;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_h <= '0;
            sda_h <= '0;
        end else begin
            scl_h <= {scl_h[0], scl_s};
            sda_h <= {sda_h[0], sda_s};
        end
    end

    // 2-of-3 vote over the current and two previous samples drops 1-clk pulses
    assign scl_f = (scl_s & scl_h[0]) | (scl_s & scl_h[1]) | (scl_h[0] & scl_h[1]);
    assign sda_f = (sda_s & sda_h[0]) | (sda_s & sda_h[1]) | (sda_h[0] & sda_h[1]);
`else
    assign scl_f = scl_s;
    assign sda_f = sda_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_d <= 1'b0;
            sda_d <= 1'b0;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_c   = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_c    = scl_f & scl_d & ~sda_d & sda_f;
    assign rx_byte   = {rx_sr, sda_f};
    assign byte_done = scl_rise && (bit_cnt == 4'd7);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Byte states count 8 rising edges, then hand over to the ACK state on the next falling edge
    always_comb begin
        state_nxt = state;
        ptr_ld    = 1'b0;
        wr_en     = 1'b0;
        tx_ld     = 1'b0;
        case (state)
            ACK_ADDR, ACK_PTR, ACK_W: sda_oe = 1'b1;
            RDATA:                    sda_oe = ~tx_sr[7];
            default:                  sda_oe = 1'b0;
        endcase
        if (stop_c) begin
            state_nxt = IDLE;
        end else if (start_c) begin
            state_nxt = ADDR;
        end else begin
            case (state)
                ADDR: begin
                    if (byte_done && (rx_byte[7:1] != I2C_ADDR)) state_nxt = IDLE;
                    else if (scl_fall && (bit_cnt == 4'd8))      state_nxt = ACK_ADDR;
                end
                ACK_ADDR: begin
                    if (scl_fall) begin
                        if (rw) begin
                            state_nxt = RDATA;
                            tx_ld     = 1'b1;
                        end else begin
                            state_nxt = PTR;
                        end
                    end
                end
                PTR: begin
                    ptr_ld = byte_done;
                    if (scl_fall && (bit_cnt == 4'd8)) state_nxt = ACK_PTR;
                end
                ACK_PTR: if (scl_fall) state_nxt = WDATA;
                WDATA: begin
                    wr_en = byte_done;
                    if (scl_fall && (bit_cnt == 4'd8)) state_nxt = ACK_W;
                end
                ACK_W: if (scl_fall) state_nxt = WDATA;
                RDATA: if (scl_fall && (bit_cnt == 4'd8)) state_nxt = ACK_R;
                ACK_R: begin
                    if (scl_fall) begin
                        if (m_nack) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = RDATA;
                            tx_ld     = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            rx_sr   <= '0;
            tx_sr   <= '0;
            ptr     <= '0;
            rw      <= 1'b0;
            m_nack  <= 1'b0;
        end else begin
            if (start_c || (state_nxt != state)) bit_cnt <= '0;
            else if (scl_rise && (bit_cnt != 4'd8)) bit_cnt <= bit_cnt + 4'd1;
            if (scl_rise) rx_sr <= rx_byte[6:0];
            if ((state == ADDR) && byte_done) rw <= sda_f;
            if ((state == ACK_R) && scl_rise) m_nack <= sda_f;
            if (tx_ld) tx_sr <= rd_data;
            else if ((state == RDATA) && scl_fall) tx_sr <= {tx_sr[6:0], 1'b0};
            // Pointer increments after every written or captured byte, wrapping naturally at 8 bits
            if (ptr_ld) ptr <= rx_byte;
            else if (wr_en || tx_ld) ptr <= ptr + 8'd1;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (ptr)
            8'h00:   rd_data = CHIP_ID;
            8'h01:   rd_data = {3'b000, ctrl};
            8'h02:   rd_data = {2'b00, ocp_flag, ts_s, dn_s, dp_s, cc2_s, cc1_s};
            8'h03:   rd_data = {3'b000, gpio_out};
            8'h04:   rd_data = {3'b000, gpio_oe_r};
            8'h05:   rd_data = {3'b000, gpio_s};
            8'h06:   rd_data = scratch;
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl      <= '0;
            gpio_out  <= '0;
            gpio_oe_r <= '0;
            scratch   <= '0;
            ocp_flag  <= 1'b0;
        end else begin
            if (wr_en) begin
                case (ptr)
                    8'h01:   ctrl      <= rx_byte[4:0];
                    8'h02:   if (rx_byte[5]) ocp_flag <= 1'b0;
                    8'h03:   gpio_out  <= rx_byte[4:0];
                    8'h04:   gpio_oe_r <= rx_byte[4:0];
                    8'h06:   scratch   <= rx_byte;
                    default: ;
                endcase
            end
            // Over-current wins over any same-cycle write to the enables or the flag
            if (ocp_s) begin
                ctrl[1:0] <= 2'b00;
                ocp_flag  <= 1'b1;
            end
        end
    end

    assign gate_en  = ctrl[0];
    assign buck_en  = ctrl[1];
    assign vdrv_en  = ctrl[2];
    assign cc_rp_en = ctrl[4:3];
    assign gpio_oe  = tst_s ? 5'h1F : gpio_oe_r;
    assign gpio_o   = tst_s ? {ctrl[1], ctrl[0], ocp_flag, cc2_s, cc1_s} : gpio_out;

endmodule

// File: tb/tb_chip_top_1127a0.sv
// Bench for chip_top_1127a0: bit-banged I2C master, register-map reference model, queue scoreboard.
`timescale 1ns/1ps
module tb_chip_top_1127a0;

    localparam int         Q    = 4;
    localparam logic [6:0] SADR = 7'h4A;

    logic       clk = 1'b0;
    logic       rst, scl_m, sda_m, sda_line, sda_oe, tst;
    logic [4:0] gpio_in, gpio_o, gpio_oe;
    logic       cc1, cc2, dp, dn, ts, ocp;
    logic       gate_en, buck_en, vdrv_en;
    logic [1:0] cc_rp_en;

    always #5 clk = ~clk;
    assign sda_line = sda_m & ~sda_oe;

    chip_top_1127a0 dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
        .tst_i(tst), .gpio_i(gpio_in), .gpio_o(gpio_o), .gpio_oe(gpio_oe),
        .cc1_cmp_i(cc1), .cc2_cmp_i(cc2), .dp_cmp_i(dp), .dn_cmp_i(dn),
        .ts_cmp_i(ts), .ocp_i(ocp), .gate_en(gate_en), .buck_en(buck_en),
        .vdrv_en(vdrv_en), .cc_rp_en(cc_rp_en)
    );

    // Scoreboard
    string      exp_name_q[$];
    logic [7:0] exp_val_q[$];
    logic [7:0] obs_q[$];
    int         n_chk = 0;
    int         n_fail = 0;

    function automatic void push_exp(input string nm, input logic [7:0] v);
        exp_name_q.push_back(nm);
        exp_val_q.push_back(v);
    endfunction

    function automatic void push_obs(input logic [7:0] v);
        obs_q.push_back(v);
    endfunction

    initial begin : monitor
        logic [7:0] got, want;
        string      nm;
        forever begin
            @(negedge clk);
            while (obs_q.size() > 0) begin
                got = obs_q.pop_front();
                n_chk++;
                if (exp_val_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_obs got=%02h required=none", got);
                end else begin
                    want = exp_val_q.pop_front();
                    nm   = exp_name_q.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL %s got=%02h required=%02h", nm, got, want);
                    end
                end
            end
        end
    end

    // Reference model of the register map
    logic [4:0] m_ctrl, m_gout, m_goe;
    logic [7:0] m_scr, m_ptr;
    logic       m_flag;

    function automatic void m_reset();
        m_ctrl = '0; m_gout = '0; m_goe = '0; m_scr = '0; m_ptr = '0; m_flag = 1'b0;
    endfunction

    function automatic void m_ocp();
        if (ocp) begin
            m_ctrl[1:0] = 2'b00;
            m_flag      = 1'b1;
        end
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        case (a)
            8'h00:   return 8'h27;
            8'h01:   return {3'b000, m_ctrl};
            8'h02:   return {2'b00, m_flag, ts, dn, dp, cc2, cc1};
            8'h03:   return {3'b000, m_gout};
            8'h04:   return {3'b000, m_goe};
            8'h05:   return {3'b000, gpio_in};
            8'h06:   return m_scr;
            default: return 8'h00;
        endcase
    endfunction

    function automatic void m_write(input logic [7:0] a, input logic [7:0] d);
        case (a)
            8'h01:   m_ctrl = d[4:0];
            8'h02:   if (d[5]) m_flag = 1'b0;
            8'h03:   m_gout = d[4:0];
            8'h04:   m_goe  = d[4:0];
            8'h06:   m_scr  = d;
            default: ;
        endcase
        m_ocp();
    endfunction

    // I2C master
    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(2 * Q);
        sda_m = 1'b0; wclk(2 * Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wclk(Q);
        scl_m = 1'b1; wclk(2 * Q);
        sda_m = 1'b1; wclk(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wclk(Q);
        scl_m = 1'b1; wclk(2 * Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        b = sda_line; wclk(Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic wbyte(input logic [7:0] b, input string nm, input logic exp_ack);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(a);
        push_exp(nm, {7'b0, exp_ack});
        push_obs({7'b0, a});
    endtask

    task automatic rbyte(output logic [7:0] v, input logic nack);
        logic b;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b);
            v = {v[6:0], b};
        end
        send_bit(nack);
    endtask

    task automatic i2c_write(input logic [7:0] p, input int n,
                             input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic [7:0] d [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        i2c_start();
        wbyte({SADR, 1'b0}, "wr_addr_ack", 1'b0);
        wbyte(p, "ptr_ack", 1'b0);
        m_ptr = p;
        for (int i = 0; i < n; i++) begin
            wbyte(d[i], "wr_data_ack", 1'b0);
            m_write(m_ptr, d[i]);
            m_ptr = m_ptr + 8'd1;
        end
        i2c_stop();
    endtask

    task automatic i2c_read(input logic [7:0] p, input int n, input logic use_ptr);
        logic [7:0] v;
        i2c_start();
        if (use_ptr) begin
            wbyte({SADR, 1'b0}, "wr_addr_ack", 1'b0);
            wbyte(p, "ptr_ack", 1'b0);
            m_ptr = p;
            i2c_start();
        end
        wbyte({SADR, 1'b1}, "rd_addr_ack", 1'b0);
        for (int i = 0; i < n; i++) begin
            push_exp($sformatf("rd_reg_%02h", m_ptr), m_read(m_ptr));
            m_ptr = m_ptr + 8'd1;
            rbyte(v, (i == n - 1));
            push_obs(v);
        end
        i2c_stop();
    endtask

    task automatic check_pins();
        wclk(4);
        push_exp("enables", {3'b000, m_ctrl});
        push_obs({3'b000, cc_rp_en, vdrv_en, buck_en, gate_en});
        push_exp("gpio_o", {3'b000, tst ? {m_ctrl[1], m_ctrl[0], m_flag, cc2, cc1} : m_gout});
        push_obs({3'b000, gpio_o});
        push_exp("gpio_oe", {3'b000, tst ? 5'h1F : m_goe});
        push_obs({3'b000, gpio_oe});
        push_exp("sda_oe_idle", 8'h00);
        push_obs({7'b0, sda_oe});
    endtask

    initial begin : watchdog
        #800000;
        n_fail++;
        $display("FAIL watchdog timeout");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic b;
        int   r;
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tst = 1'b0; gpio_in = '0;
        cc1 = 0; cc2 = 0; dp = 0; dn = 0; ts = 0; ocp = 0;
        m_reset();
        wclk(5);
        rst = 1'b0;
        wclk(5);

        // Reset state and ID read from the reset pointer
        check_pins();
        i2c_read(8'h00, 1, 1'b0);

        // CTRL write drives every enable
        i2c_write(8'h01, 1, 8'h1F, 8'h00, 8'h00);
        check_pins();
        i2c_read(8'h01, 1, 1'b1);

        // GPIO with auto-increment
        i2c_write(8'h03, 2, 8'h15, 8'h1F, 8'h00);
        check_pins();

        // Over-current clears gate/buck, sets sticky flag, overrides writes and W1C
        ocp = 1'b1; m_ocp();
        check_pins();
        i2c_read(8'h01, 2, 1'b1);
        i2c_write(8'h01, 1, 8'h1F, 8'h00, 8'h00);
        i2c_write(8'h02, 1, 8'h20, 8'h00, 8'h00);
        check_pins();
        i2c_read(8'h01, 2, 1'b1);
        ocp = 1'b0;
        wclk(4);
        i2c_write(8'h02, 1, 8'h20, 8'h00, 8'h00);
        i2c_read(8'h02, 1, 1'b1);

        // Wrong address is ignored; STOP mid-byte returns to idle
        i2c_write(8'h06, 1, 8'h5A, 8'h00, 8'h00);
        i2c_start();
        wbyte({7'h4B, 1'b0}, "bad_addr_nack", 1'b1);
        wbyte(8'h06, "bad_ptr_nack", 1'b1);
        wbyte(8'hA5, "bad_data_nack", 1'b1);
        i2c_stop();
        i2c_start();
        wbyte({SADR, 1'b0}, "wr_addr_ack", 1'b0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        i2c_stop();
        check_pins();
        i2c_read(8'h06, 1, 1'b1);

        // Pointer wrap 0xFF -> 0x00 -> 0x01
        i2c_write(8'hFF, 3, 8'h11, 8'h22, 8'h0A);
        check_pins();
        i2c_read(8'hFF, 3, 1'b1);

        // Randomized traffic
        for (int it = 0; it < 24; it++) begin
            {cc1, cc2, dp, dn, ts} = 5'($urandom);
            gpio_in = 5'($urandom);
            wclk(4);
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 1)
                i2c_write((r < 8) ? 8'(r) : 8'($urandom), $urandom_range(1, 3),
                          8'($urandom), 8'($urandom), 8'($urandom));
            else
                i2c_read((r < 8) ? 8'(r) : 8'($urandom), $urandom_range(1, 3), 1'b1);
            check_pins();
        end

        // TST observation mux
        i2c_write(8'h01, 1, 8'h01, 8'h00, 8'h00);
        cc1 = 1'b1; cc2 = 1'b0;
        tst = 1'b1;
        check_pins();
        i2c_read(8'h01, 1, 1'b1);
        tst = 1'b0;

        // Reset in the middle of a read while the slave drives a 0
        i2c_write(8'h00, 0, 8'h00, 8'h00, 8'h00);
        i2c_start();
        wbyte({SADR, 1'b1}, "rd_addr_ack", 1'b0);
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        push_exp("rd_msb_drive", 8'h01);
        push_obs({7'b0, sda_oe});
        rst = 1'b1;
        wclk(1);
        push_exp("sda_oe_after_rst", 8'h00);
        push_obs({7'b0, sda_oe});
        m_reset();
        check_pins();
        rst = 1'b0;
        wclk(5);
        i2c_read(8'h00, 1, 1'b0);
        i2c_read(8'h01, 1, 1'b1);

        for (int k = 0; k < 50 && obs_q.size() > 0; k++) wclk(1);
        while (exp_val_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL missing_obs %s got=none required=%02h",
                     exp_name_q.pop_front(), exp_val_q.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
